// File: rtl/stopwatch_ctrl_if.sv
// Stopwatch control bundle: debounced button levels in, counter/display controls out.
interface stopwatch_ctrl_if;
  logic [3:0] btn;
  logic       run;
  logic       freeze;
  logic       clear;
  logic       down;
  logic [1:0] state;

  modport master (output btn, input run, freeze, clear, down, state);
  modport slave  (input btn, output run, freeze, clear, down, state);
endinterface

// File: rtl/stopwatch_ctrl.sv
// Stopwatch control FSM: debounced buttons -> run/freeze/clear/down commands.
// Optional LAP_AUTORELEASE_EN adds a lap timer that returns LAP to RUN after LAP_CYCLES.
module stopwatch_ctrl #(
  parameter int HOLD_CYCLES = 100_000_000,
`ifdef LAP_AUTORELEASE_EN
  parameter int LAP_CYCLES  = 250_000_000,
`endif
  parameter int CNT_W       = 28
) (
  input  logic            clk_50M,
  input  logic            reset_n,
  stopwatch_ctrl_if.slave sw
);

  typedef enum logic [1:0] {IDLE = 2'b00, RUN = 2'b01, PAUSE = 2'b10, LAP = 2'b11} state_e;

  localparam logic [CNT_W-1:0] HOLD_MAX = CNT_W'(HOLD_CYCLES - 1);

  state_e           state_q, state_d;
  logic             run_q, run_d, freeze_q, freeze_d, clear_q, clear_d, down_q, down_d;
  logic [3:0]       btn_q;
  logic [CNT_W-1:0] hold_q, hold_d;
  logic [3:0]       press;
  logic             w_clr, w_start, w_lap, w_dir;
  logic             hold_fire, lap_expire;

  // Only the highest-priority press acts; the others are swallowed.
  assign press   = sw.btn & ~btn_q;
  assign w_clr   = press[2];
  assign w_start = press[0] & ~press[2];
  assign w_lap   = press[1] & ~press[2] & ~press[0];
  assign w_dir   = press[3] & ~press[2] & ~press[0] & ~press[1];

  assign hold_fire = ((state_q == RUN) || (state_q == LAP)) && sw.btn[2] && (hold_q == HOLD_MAX);

`ifdef LAP_AUTORELEASE_EN
  localparam logic [CNT_W-1:0] LAP_MAX = CNT_W'(LAP_CYCLES - 1);
  logic [CNT_W-1:0] lap_q, lap_d;

  assign lap_expire = (lap_q == LAP_MAX);

  always_comb begin
    lap_d = '0;
    if ((state_q == LAP) && (state_d == LAP)) lap_d = lap_q + CNT_W'(1);
  end

  always_ff @(posedge clk_50M or negedge reset_n) begin
    if (!reset_n) lap_q <= '0;
    else          lap_q <= lap_d;
  end
`else
  assign lap_expire = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    clear_d = 1'b0;
    down_d  = down_q;
    if (hold_fire) begin
      state_d = IDLE;
      clear_d = 1'b1;
    end else begin
      case (state_q)
        IDLE: begin
          if (w_start)    state_d = RUN;
          else if (w_clr) clear_d = 1'b1;
          else if (w_dir) down_d  = ~down_q;
        end
        RUN: begin
          if (w_start)    state_d = PAUSE;
          else if (w_lap) state_d = LAP;
        end
        LAP: begin
          if (w_lap)           state_d = RUN;
          else if (w_start)    state_d = PAUSE;
          else if (lap_expire) state_d = RUN;
        end
        PAUSE: begin
          if (w_start) state_d = RUN;
          else if (w_clr) begin
            state_d = IDLE;
            clear_d = 1'b1;
          end
        end
        default: state_d = IDLE;
      endcase
    end

    // Saturates so a long hold fires once; restarts on release or any transition.
    if (!sw.btn[2] || (state_d != state_q)) hold_d = '0;
    else if (hold_q == HOLD_MAX)            hold_d = hold_q;
    else                                    hold_d = hold_q + CNT_W'(1);

    run_d    = (state_d == RUN) || (state_d == LAP);
    freeze_d = (state_d == LAP);
  end

  always_ff @(posedge clk_50M or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      run_q    <= 1'b0;
      freeze_q <= 1'b0;
      clear_q  <= 1'b0;
      down_q   <= 1'b0;
      btn_q    <= 4'b1111;
      hold_q   <= '0;
    end else begin
      state_q  <= state_d;
      run_q    <= run_d;
      freeze_q <= freeze_d;
      clear_q  <= clear_d;
      down_q   <= down_d;
      btn_q    <= sw.btn;
      hold_q   <= hold_d;
    end
  end

  assign sw.run    = run_q;
  assign sw.freeze = freeze_q;
  assign sw.clear  = clear_q;
  assign sw.down   = down_q;
  assign sw.state  = state_q;

endmodule
